// File: rtl/scoreboard_hazard_ctrl.sv
// Issue-stage hazard controller: per-register pending-write counters drive RAW/WAW stalls,
// writeback bypass selects and stall performance counters.
module scoreboard_hazard_ctrl #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned IDXW  = 5,
    parameter int unsigned CNTW  = 2,
    parameter int unsigned PERFW = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [IDXW-1:0]  id_rs1,
    input  logic [IDXW-1:0]  id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [IDXW-1:0]  id_rd,
    input  logic             id_rd_we,
    input  logic             wb_valid,
    input  logic [IDXW-1:0]  wb_rd,
    output logic             id_stall,
    output logic             id_issue,
    output logic             fwd_rs1_wb,
    output logic             fwd_rs2_wb,
    output logic [PERFW-1:0] stall_total,
    output logic [PERFW-1:0] stall_max_run
);

    localparam logic [CNTW-1:0]  CntMax  = '1;
    localparam logic [CNTW-1:0]  CntOne  = CNTW'(1);
    localparam logic [PERFW-1:0] PerfMax = '1;
    localparam logic [PERFW-1:0] PerfOne = PERFW'(1);

    typedef enum logic {StRun, StStall} state_e;

    logic [CNTW-1:0]  cnt_q [NREGS];
    logic [CNTW-1:0]  cnt_d [NREGS];
    state_e           state_q, state_d;
    logic [PERFW-1:0] run_q, run_d;
    logic [PERFW-1:0] max_q, max_d;
    logic [PERFW-1:0] total_q, total_d;

    logic [CNTW-1:0] cnt_rs1, cnt_rs2, cnt_rd, cnt_wb;
    logic            hit1, hit2, byp1, byp2, waw_full;
    logic            issue_wr, wb_hit;

    always_comb begin
        cnt_rs1  = cnt_q[id_rs1];
        cnt_rs2  = cnt_q[id_rs2];
        cnt_rd   = cnt_q[id_rd];
        cnt_wb   = cnt_q[wb_rd];
        hit1     = id_rs1_used && (id_rs1 != '0) && (cnt_rs1 != '0);
        hit2     = id_rs2_used && (id_rs2 != '0) && (cnt_rs2 != '0);
        // Bypass only when the writeback is the sole outstanding write.
        byp1     = wb_valid && (wb_rd == id_rs1) && (cnt_rs1 == CntOne);
        byp2     = wb_valid && (wb_rd == id_rs2) && (cnt_rs2 == CntOne);
        waw_full = id_rd_we && (id_rd != '0) && (cnt_rd == CntMax)
                   && !(wb_valid && (wb_rd == id_rd));
        id_stall   = !rst && id_valid && ((hit1 && !byp1) || (hit2 && !byp2) || waw_full);
        id_issue   = !rst && id_valid && !id_stall;
        fwd_rs1_wb = id_issue && hit1 && byp1;
        fwd_rs2_wb = id_issue && hit2 && byp2;
        issue_wr   = id_issue && id_rd_we && (id_rd != '0);
        wb_hit     = wb_valid && (wb_rd != '0);
    end

    // Issue and retire to the same register cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (issue_wr && !(wb_hit && (wb_rd == id_rd))) begin
            cnt_d[id_rd] = cnt_rd + CntOne;
        end
        if (wb_hit && (cnt_wb != '0) && !(issue_wr && (wb_rd == id_rd))) begin
            cnt_d[wb_rd] = cnt_wb - CntOne;
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        max_d   = max_q;
        total_d = total_q;
        if (id_stall && (total_q != PerfMax)) begin
            total_d = total_q + PerfOne;
        end
        unique case (state_q)
            StRun: begin
                if (id_stall) begin
                    state_d = StStall;
                    run_d   = PerfOne;
                end
            end
            StStall: begin
                if (id_stall) begin
                    if (run_q != PerfMax) run_d = run_q + PerfOne;
                end else begin
                    state_d = StRun;
                    run_d   = '0;
                end
            end
            default: state_d = StRun;
        endcase
        if (id_stall && (run_d > max_q)) begin
            max_d = run_d;
        end else if (!id_stall && (state_q == StStall) && (run_q > max_q)) begin
            max_d = run_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                cnt_q[r] <= '0;
            end
            state_q <= StRun;
            run_q   <= '0;
            max_q   <= '0;
            total_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            run_q   <= run_d;
            max_q   <= max_d;
            total_q <= total_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(wb_hit && (cnt_wb == '0) && !(issue_wr && (wb_rd == id_rd))))
            else $warning("writeback to register %0d with no pending write", wb_rd);
        end
    end

    assign stall_total   = total_q;
    assign stall_max_run = max_q;

endmodule
